// File: rtl/imem_load_tx.sv
// Transmitter for the instruction-memory load protocol: serialises a 10-bit address
// and a 40-bit word as 7 strobed bytes on port a, then pulses imem_write.
module imem_load_tx #(
  parameter int PHASE_CYCLES = 4,
  parameter int ADR_WIDTH    = 10,
  parameter int WORD_WIDTH   = 40
) (
  input  logic                  clk_int,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADR_WIDTH-1:0]  adr,
  input  logic [WORD_WIDTH-1:0] data,
  input  logic                  mode_memload,
  output logic [7:0]            io_a_out,
  output logic                  imem_clock_out,
  output logic                  imem_write_out,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);

  localparam logic [7:0] PH_LAST   = 8'(PHASE_CYCLES - 1);
  localparam logic [2:0] BYTE_LAST = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    CLK_HI = 3'd2,
    CLK_LO = 3'd3,
    WRITE  = 3'd4,
    GAP    = 3'd5
  } state_t;

  state_t                  state_r, state_s;
  logic [7:0]              phase_r, phase_s;
  logic [2:0]              byte_r, byte_s;
  logic                    half_r, half_s;
  logic                    load_s, abort_s, phase_end_s;
  logic [ADR_WIDTH-1:0]    adr_r, adr_src_s;
  logic [WORD_WIDTH-1:0]   data_r, data_src_s;

  // Byte idx of the MSB-first frame {6'b0, adr, data}.
  function automatic logic [7:0] byte_sel(input logic [2:0] idx,
                                          input logic [ADR_WIDTH-1:0] a,
                                          input logic [WORD_WIDTH-1:0] d);
    logic [55:0] frame;
    frame = 56'({a, d});
    case (idx)
      3'd0:    byte_sel = frame[55:48];
      3'd1:    byte_sel = frame[47:40];
      3'd2:    byte_sel = frame[39:32];
      3'd3:    byte_sel = frame[31:24];
      3'd4:    byte_sel = frame[23:16];
      3'd5:    byte_sel = frame[15:8];
      3'd6:    byte_sel = frame[7:0];
      default: byte_sel = 8'h00;
    endcase
  endfunction

  // Next-state, counter and capture decode.
  always_comb begin
    state_s     = state_r;
    phase_s     = phase_r;
    byte_s      = byte_r;
    half_s      = half_r;
    load_s      = 1'b0;
    abort_s     = 1'b0;
    adr_src_s   = adr_r;
    data_src_s  = data_r;
    phase_end_s = (phase_r == PH_LAST);
    if (state_r == IDLE) begin
      if (start && mode_memload) begin
        load_s     = 1'b1;
        adr_src_s  = adr;
        data_src_s = data;
        state_s    = SETUP;
        phase_s    = 8'd0;
        byte_s     = 3'd0;
        half_s     = 1'b0;
      end else begin
        state_s = IDLE;
      end
    // The last GAP cycle has already signalled done, so a mode drop there is not an abort.
    end else if (!mode_memload && !((state_r == GAP) && phase_end_s)) begin
      abort_s = 1'b1;
      state_s = IDLE;
      phase_s = 8'd0;
      byte_s  = 3'd0;
      half_s  = 1'b0;
    end else if (!phase_end_s) begin
      phase_s = phase_r + 8'd1;
    end else begin
      phase_s = 8'd0;
      case (state_r)
        SETUP:  state_s = CLK_HI;
        CLK_HI: state_s = CLK_LO;
        CLK_LO: begin
          if (byte_r == BYTE_LAST) begin
            state_s = WRITE;
          end else begin
            byte_s  = byte_r + 3'd1;
            state_s = SETUP;
          end
        end
        // WRITE spans two phase-counter rounds so the 8-bit counter never overflows.
        WRITE: begin
          if (half_r) begin
            half_s  = 1'b0;
            state_s = GAP;
          end else begin
            half_s  = 1'b1;
          end
        end
        GAP: begin
          state_s = IDLE;
          byte_s  = 3'd0;
        end
        default: begin
          state_s = IDLE;
          byte_s  = 3'd0;
          half_s  = 1'b0;
        end
      endcase
    end
  end

  // State registers and outputs registered from the next-state decode.
  always_ff @(posedge clk_int) begin
    if (!reset) begin
      state_r        <= IDLE;
      phase_r        <= 8'd0;
      byte_r         <= 3'd0;
      half_r         <= 1'b0;
      adr_r          <= '0;
      data_r         <= '0;
      io_a_out       <= 8'h00;
      imem_clock_out <= 1'b0;
      imem_write_out <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
    end else begin
      state_r        <= state_s;
      phase_r        <= phase_s;
      byte_r         <= byte_s;
      half_r         <= half_s;
      if (load_s) begin
        adr_r  <= adr;
        data_r <= data;
      end
      io_a_out       <= (state_s == IDLE) ? 8'h00 : byte_sel(byte_s, adr_src_s, data_src_s);
      imem_clock_out <= (state_s == CLK_HI);
      imem_write_out <= (state_s == WRITE);
      busy           <= (state_s != IDLE);
      done           <= (state_s == GAP) && (phase_s == PH_LAST);
      aborted        <= abort_s;
    end
  end

endmodule
